uart_tx_arbiter: RTL



---
 rtl/uart_tx_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the uart_tx round-robin arbiter.
package uart_tx_arb_pkg;

    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        XFER    = 3'd2,
        RELEASE = 3'd3,
        LOCKED  = 3'd4
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after rr_ptr, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [2*N_REQ-1:0] rot;
    int                 sum;

    // Doubling the vector lets a plain shift act as a rotation
    assign rot = {req, req} >> rr_ptr;

    always_comb begin
        pick = '0;
        any  = 1'b0;
        sum  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum  = int'(rr_ptr) + k;
                any  = 1'b1;
                pick = IDX_W'((sum >= N_REQ) ? sum - N_REQ : sum);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx among N_REQ requesters, round-robin with per-requester message lock.
// Optional idle-lock watchdog and lock_timeout port: define UART_TX_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int IDX_W       = 2,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_start,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_lock,
    output logic [N_REQ-1:0]        req_busy,
    input  logic                    uart_tx_busy,
    output logic                    uart_tx_start,
    output logic [DATA_W-1:0]       uart_tx_data,
    output logic                    grant_valid,
    output logic [IDX_W-1:0]        grant_idx
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    ,
    output logic                    lock_timeout
`endif
);

    arb_state_t       state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick;
    logic             any_req;
    logic             issue_go;
    logic [IDX_W-1:0] issue_idx;
    logic             owner_req;
    logic             owner_lock;
    logic [IDX_W-1:0] next_ptr;

`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req_start),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .any    (any_req)
    );

    assign owner_req  = req_start[grant_idx];
    assign owner_lock = req_lock[grant_idx];
    assign next_ptr   = IDX_W'(wrap_inc(int'(grant_idx), N_REQ));

    // A stale busy from uart_tx blocks any new issue, locked or not
    always_comb begin
        issue_go  = 1'b0;
        issue_idx = pick;
        if (state == IDLE) begin
            issue_go = any_req && !uart_tx_busy;
        end else if (state == LOCKED) begin
            issue_idx = grant_idx;
            issue_go  = owner_req && !uart_tx_busy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            grant_valid   <= 1'b0;
            grant_idx     <= '0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            req_busy      <= '0;
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
            idle_cnt      <= '0;
            lock_timeout  <= 1'b0;
`endif
        end else begin
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
            lock_timeout <= 1'b0;
            if (state != LOCKED || owner_req)
                idle_cnt <= '0;
            else
                idle_cnt <= idle_cnt + 1'b1;
`endif
            case (state)
                IDLE, LOCKED: begin
                    if (issue_go) begin
                        grant_valid         <= 1'b1;
                        grant_idx           <= issue_idx;
                        uart_tx_data        <= req_data[int'(issue_idx)*DATA_W +: DATA_W];
                        uart_tx_start       <= 1'b1;
                        req_busy            <= '0;
                        req_busy[issue_idx] <= 1'b1;
                        state               <= ISSUE;
                    end else if (state == LOCKED && !owner_lock) begin
                        rr_ptr      <= next_ptr;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
`ifdef UART_TX_ARB_LOCK_TIMEOUT_EN
                    else if (state == LOCKED && idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        rr_ptr       <= next_ptr;
                        grant_valid  <= 1'b0;
                        lock_timeout <= 1'b1;
                        state        <= IDLE;
                    end
`endif
                end
                ISSUE: begin
                    if (uart_tx_busy) begin
                        uart_tx_start <= 1'b0;
                        state         <= XFER;
                    end
                end
                XFER: begin
                    if (!uart_tx_busy) begin
                        req_busy <= '0;
                        state    <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!owner_req) begin
                        if (owner_lock) begin
                            state <= LOCKED;
                        end else begin
                            rr_ptr      <= next_ptr;
                            grant_valid <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    grant_valid   <= 1'b0;
                    grant_idx     <= '0;
                    uart_tx_start <= 1'b0;
                    uart_tx_data  <= '0;
                    req_busy      <= '0;
                end
            endcase
        end
    end

endmodule
